// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, FSM state type and flag-mask helpers for alu_issue_ctrl
//
// Holds the ALU operation codes, the datapath width, the controller state
// encoding and the two helpers that say which ALU flags are meaningful for
// a given operation.

package alu_pkg;

    localparam int WIDTH = 16;

    // ALU operation codes; 15 never reaches the ALU and selects the
    // controller-owned multiplier instead.
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_PASSA = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_DEC   = 4'd10;
    localparam logic [3:0] OP_NOP   = 4'd11;
    localparam logic [3:0] OP_CMOVZ = 4'd12;
    localparam logic [3:0] OP_MULH  = 4'd13;
    localparam logic [3:0] OP_MULL  = 4'd14;
    localparam logic [3:0] OP_MUL   = 4'd15;

    // ST_MFIX is only entered when signed multiply is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_CAPT  = 3'd2,
        ST_MUL   = 3'd3,
        ST_MDONE = 3'd4,
        ST_MFIX  = 3'd5
    } state_t;

    // Negative and overflow are only defined for the arithmetic operations.
    function automatic logic has_arith_flags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    endfunction

    // Zero reports the condition of the conditional move and nothing else.
    function automatic logic has_zero_flag(input logic [3:0] op);
        return (op == OP_CMOVZ);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_mul.sv
// rtl/alu_issue_ctrl_mul.sv - iterative shift-add multiplier (module alu_seq_mul)
//
// Unsigned WIDTH x WIDTH multiply, one partial-product step per cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             load operands and begin; ignored state is overwritten
//   mcand, mplier     multiplicand / multiplier, sampled with start
//   done              high during the final iteration cycle
//   product           2*WIDTH accumulator; complete after the done edge

module alu_seq_mul #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand_q;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic [WIDTH:0]     sum;

    // The upper half accumulates, the lower half starts as the multiplier
    // and is shifted out one bit per step, so after MUL_CYCLES steps the
    // whole register holds the product.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
    end

    assign done    = busy && (cnt == CNT_W'(MUL_CYCLES - 1));
    assign product = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand_q <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            acc     <= {{WIDTH{1'b0}}, mplier};
            mcand_q <= mcand;
            cnt     <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            acc <= {sum, acc[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/capture sequencer in front of the 16-bit registered ALU
//
// Accepts one request at a time, drives the ALU inputs, captures the ALU
// result two cycles later and returns it as a one-cycle response. Opcode 15
// runs the internal multiplier whose product feeds the ALU mulH/mulL inputs.
// Optional build macro: MUL_SIGNED_EN (two's complement multiply, adds MFIX).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_op, req_a, req_b             opcode and operands
//   rsp_valid, rsp_result            one-cycle response pulse and result
//   rsp_neg, rsp_zero, rsp_ovf       flags masked to the ops that define them
//   alu_codop, alu_op1, alu_op2      registered ALU inputs
//   alu_res, alu_neg/zero/ovf        registered ALU outputs
//   mul_hi, mul_lo                   last completed product to ALU mulH/mulL

module alu_issue_ctrl #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_neg,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic [3:0]       alu_codop,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    output logic [WIDTH-1:0] mul_hi,
    output logic [WIDTH-1:0] mul_lo
);

    import alu_pkg::*;

    state_t             state;
    logic [3:0]         op_q;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] prod_final;

    // req_ready is a registered copy of "state is IDLE".
    assign accept    = req_valid && req_ready;
    assign mul_start = accept && (req_op == OP_MUL);

`ifdef MUL_SIGNED_EN
    logic               sign_q;
    logic [2*WIDTH-1:0] prod_q;

    // Unsigned multiply of magnitudes; -32768 negates to itself, which
    // reads correctly as unsigned 32768.
    always_comb begin
        mul_a = req_a[WIDTH-1] ? -req_a : req_a;
        mul_b = req_b[WIDTH-1] ? -req_b : req_b;
    end

    assign prod_final = prod_q;
`else
    assign mul_a      = req_a;
    assign mul_b      = req_b;
    assign prod_final = mul_prod;
`endif

    alu_seq_mul #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .mcand   (mul_a),
        .mplier  (mul_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_neg    <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            alu_codop  <= OP_NOP;
            alu_op1    <= '0;
            alu_op2    <= '0;
            mul_hi     <= '0;
            mul_lo     <= '0;
            op_q       <= '0;
`ifdef MUL_SIGNED_EN
            sign_q     <= 1'b0;
            prod_q     <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= req_op;
                        req_ready <= 1'b0;
                        if (req_op == OP_MUL) begin
                            // ALU inputs are left alone so the ALU keeps
                            // recomputing the previous operation.
                            state <= ST_MUL;
`ifdef MUL_SIGNED_EN
                            sign_q <= req_a[WIDTH-1] ^ req_b[WIDTH-1];
`endif
                        end else begin
                            state     <= ST_ISSUE;
                            alu_codop <= req_op;
                            alu_op1   <= req_a;
                            alu_op2   <= req_b;
                        end
                    end
                end

                // ALU registers its inputs at the end of this cycle.
                ST_ISSUE: begin
                    state <= ST_CAPT;
                end

                ST_CAPT: begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= alu_res;
                    rsp_neg    <= has_arith_flags(op_q) & alu_neg;
                    rsp_ovf    <= has_arith_flags(op_q) & alu_ovf;
                    rsp_zero   <= has_zero_flag(op_q) & alu_zero;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end

                // mul_done marks the edge carrying the last iteration.
                ST_MUL: begin
                    if (mul_done) begin
`ifdef MUL_SIGNED_EN
                        state <= ST_MFIX;
`else
                        state <= ST_MDONE;
`endif
                    end
                end

`ifdef MUL_SIGNED_EN
                ST_MFIX: begin
                    prod_q <= sign_q ? -mul_prod : mul_prod;
                    state  <= ST_MDONE;
                end
`endif

                // Product registers change only here, so the ALU never
                // sees a partial product on mulH/mulL.
                ST_MDONE: begin
                    mul_hi     <= prod_final[2*WIDTH-1:WIDTH];
                    mul_lo     <= prod_final[WIDTH-1:0];
                    rsp_valid  <= 1'b1;
                    rsp_result <= prod_final[WIDTH-1:0];
                    rsp_neg    <= 1'b0;
                    rsp_zero   <= 1'b0;
                    rsp_ovf    <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
